// File: rtl/decoder_scan_pkg.sv
// Shared types and width helper for the decoder_scan block.
package decoder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // One-hot output width for an N-bit select.
    function automatic int w_of(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/decoder_scan_if.sv
// Request/response bundle between a requester (master) and decoder_scan (slave).
interface decoder_scan_if #(
    parameter int N = 2
);
    localparam int W = decoder_pkg::w_of(N);

    logic         in_valid;
    logic         in_ready;
    logic         mode;
    logic [N-1:0] i;
    logic [W-1:0] y;
    logic         out_valid;
    logic         scan_done;

    modport master (
        output in_valid, mode, i,
        input  in_ready, y, out_valid, scan_done
    );

    modport slave (
        input  in_valid, mode, i,
        output in_ready, y, out_valid, scan_done
    );
endinterface

// File: rtl/decoder_scan_onehot_dec.sv
// Combinational N-to-2**N one-hot decoder.
module onehot_dec
    import decoder_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]       sel,
    output logic [w_of(N)-1:0] onehot
);
    localparam int W = w_of(N);

    assign onehot = W'(1) << sel;
endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot decoder with a direct mode and a W-step wrapping scan mode.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int N = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    decoder_scan_if.slave  bus
);
    localparam int         W       = w_of(N);
    localparam logic [N:0]   CNT_ONE = (N+1)'(1);
    localparam logic [N:0]   W_CNT   = (N+1)'(W);
    localparam logic [N-1:0] IDX_ONE = N'(1);

    state_t         state;
    state_t         state_nxt;
    logic [N:0]     cnt;
    logic [N-1:0]   idx;
    logic [N-1:0]   dec_sel;
    logic [W-1:0]   dec_y;
    logic [W-1:0]   y_q;
    logic           out_valid_q;
    logic           scan_done_q;
    logic           in_ready;
    logic           accept;
    logic           step;
    logic           last_step;

    // cnt only ranges 1..W-1 while scanning, so cnt+1 never overflows N+1 bits.
    assign last_step = (cnt + CNT_ONE) == W_CNT;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (en) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && bus.mode) state_nxt = SCAN;
            SCAN:    if (last_step)          state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = en && (state == IDLE);
        accept   = bus.in_valid && in_ready;
        step     = en && (state == SCAN);
        dec_sel  = (state == SCAN) ? idx + IDX_ONE : bus.i;
    end

    onehot_dec #(.N(N)) u_dec (
        .sel    (dec_sel),
        .onehot (dec_y)
    );

    // Output register stage: decode result, scan bookkeeping, status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q         <= '0;
            out_valid_q <= 1'b0;
            scan_done_q <= 1'b0;
            cnt         <= '0;
            idx         <= '0;
        end else begin
            scan_done_q <= 1'b0;
            if (accept) begin
                y_q         <= dec_y;
                out_valid_q <= 1'b1;
                idx         <= bus.i;
                cnt         <= bus.mode ? CNT_ONE : '0;
            end else if (step) begin
                y_q <= dec_y;
                idx <= dec_sel;
                if (last_step) begin
                    cnt         <= '0;
                    scan_done_q <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_ONE;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.y         = y_q;
    assign bus.out_valid = out_valid_q;
    assign bus.scan_done = scan_done_q;
endmodule
